mem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one memory_controller port between CLIENT_COUNT requesters, such as the IF, MEM and a future DMA/debug unit. Each client sees the same rw_flag/busy/done handshake the memory controller presents. The arbiter keeps one pending request per client and forwards one request at a time downstream. It routes the completion and read data back to the owning client, with a watchdog that reports a stuck transaction as an error.

---
 rtl/mem_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mem_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one memory-controller port among several clients, with a timeout watchdog
module mem_rr_arbiter #(
  parameter int CLIENT_COUNT = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [2*CLIENT_COUNT-1:0]          cl_rw_flag,
  input  logic [ADDR_WIDTH*CLIENT_COUNT-1:0] cl_addr,
  input  logic [DATA_WIDTH*CLIENT_COUNT-1:0] cl_write_data,
  input  logic [MASK_WIDTH*CLIENT_COUNT-1:0] cl_write_mask,
  output logic [DATA_WIDTH*CLIENT_COUNT-1:0] cl_read_data,
  output logic [CLIENT_COUNT-1:0]            cl_busy,
  output logic [CLIENT_COUNT-1:0]            cl_done,
  output logic [CLIENT_COUNT-1:0]            cl_err,
  output logic [1:0]                         mc_rw_flag,
  output logic [ADDR_WIDTH-1:0]              mc_addr,
  output logic [DATA_WIDTH-1:0]              mc_write_data,
  output logic [MASK_WIDTH-1:0]              mc_write_mask,
  input  logic                               mc_busy,
  input  logic                               mc_done,
  input  logic [DATA_WIDTH-1:0]              mc_read_data
);
  localparam int GW = $clog2(CLIENT_COUNT);
  localparam logic [31:0] TO = TIMEOUT;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0]            sl_flag [CLIENT_COUNT];
  logic [ADDR_WIDTH-1:0] sl_addr [CLIENT_COUNT];
  logic [DATA_WIDTH-1:0] sl_data [CLIENT_COUNT];
  logic [MASK_WIDTH-1:0] sl_mask [CLIENT_COUNT];
  logic [GW-1:0] grant, last_grant, pick, j;
  logic pick_ok, issue, fin, abort;
  logic [31:0] wd;
  // find the first pending slot after last_grant; scanning downward lets the nearest one win
  always_comb begin
    pick_ok = 1'b0;
    pick = last_grant;
    j = '0;
    for (int k = CLIENT_COUNT; k > 0; k--) begin
      j = GW'((int'(last_grant) + k) % CLIENT_COUNT);
      if (cl_busy[j]) begin
        pick_ok = 1'b1;
        pick = j;
      end
    end
  end
  // next state: issue from IDLE when the port is free, return on completion or watchdog expiry
  always_comb begin
    issue = state == IDLE && pick_ok && !mc_busy;
    fin = state == WAIT && mc_done;
    abort = state == WAIT && !mc_done && TIMEOUT != 0 && wd + 32'd1 == TO;
    state_n = issue ? WAIT : (fin || abort) ? IDLE : state;
  end
  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else state <= state_n;
  end
  // downstream request: one-cycle flag pulse, address/data/mask held until the next issue
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mc_rw_flag <= 2'd0;
      mc_addr <= '0;
      mc_write_data <= '0;
      mc_write_mask <= '0;
      grant <= '0;
      last_grant <= GW'(CLIENT_COUNT - 1);
      wd <= '0;
    end else begin
      mc_rw_flag <= issue ? sl_flag[pick] : 2'd0;
      if (issue) begin
        mc_addr <= sl_addr[pick];
        mc_write_data <= sl_data[pick];
        mc_write_mask <= sl_mask[pick];
        grant <= pick;
        last_grant <= pick;
        wd <= '0;
      end else if (state == WAIT) wd <= wd + 32'd1;
    end
  end
  // per-client slots: capture when idle, release and report on completion or timeout
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CLIENT_COUNT; i++) begin
        sl_flag[i] <= 2'd0;
        sl_addr[i] <= '0;
        sl_data[i] <= '0;
        sl_mask[i] <= '0;
      end
      cl_busy <= '0;
      cl_done <= '0;
      cl_err <= '0;
      cl_read_data <= '0;
    end else begin
      for (int i = 0; i < CLIENT_COUNT; i++) begin
        cl_done[i] <= (fin || abort) && grant == GW'(i);
        cl_err[i] <= abort && grant == GW'(i);
        if (fin && grant == GW'(i) && sl_flag[i] == 2'd1)
          cl_read_data[i*DATA_WIDTH +: DATA_WIDTH] <= mc_read_data;
        if (!cl_busy[i] && (cl_rw_flag[2*i +: 2] == 2'd1 || cl_rw_flag[2*i +: 2] == 2'd2)) begin
          sl_flag[i] <= cl_rw_flag[2*i +: 2];
          sl_addr[i] <= cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          sl_data[i] <= cl_write_data[i*DATA_WIDTH +: DATA_WIDTH];
          sl_mask[i] <= cl_write_mask[i*MASK_WIDTH +: MASK_WIDTH];
          cl_busy[i] <= 1'b1;
        end else if ((fin || abort) && grant == GW'(i)) begin
          sl_flag[i] <= 2'd0;
          cl_busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vector table plus reset sequences for mem_rr_arbiter
module tb_mem_rr_arbiter;
  logic CLK = 1'b0;
  logic RST_N;
  logic [7:0] cl_rw_flag;
  logic [127:0] cl_addr, cl_write_data, cl_read_data;
  logic [15:0] cl_write_mask;
  logic [3:0] cl_busy, cl_done, cl_err;
  logic [1:0] mc_rw_flag;
  logic [31:0] mc_addr, mc_write_data, mc_read_data;
  logic [3:0] mc_write_mask;
  logic mc_busy, mc_done;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] f;
    logic b, d;
    logic [31:0] rd;
    logic [1:0] emf;
    logic [31:0] ea;
    logic [3:0] eb, ed, ee;
  } vec_t;
  vec_t tv[$];

  mem_rr_arbiter #(.CLIENT_COUNT(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .cl_rw_flag(cl_rw_flag), .cl_addr(cl_addr),
    .cl_write_data(cl_write_data), .cl_write_mask(cl_write_mask), .cl_read_data(cl_read_data),
    .cl_busy(cl_busy), .cl_done(cl_done), .cl_err(cl_err), .mc_rw_flag(mc_rw_flag),
    .mc_addr(mc_addr), .mc_write_data(mc_write_data), .mc_write_mask(mc_write_mask),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_read_data(mc_read_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] f, input logic b, input logic d, input logic [31:0] rd,
                     input logic [1:0] emf, input logic [31:0] ea,
                     input logic [3:0] eb, input logic [3:0] ed, input logic [3:0] ee);
    vec_t v;
    v.f = f; v.b = b; v.d = d; v.rd = rd;
    v.emf = emf; v.ea = ea; v.eb = eb; v.ed = ed; v.ee = ee;
    tv.push_back(v);
  endtask

  task automatic step(input logic [7:0] f, input logic b, input logic d, input logic [31:0] rd);
    cl_rw_flag = f;
    mc_busy = b;
    mc_done = d;
    mc_read_data = rd;
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mc_rw_flag"}, mc_rw_flag, 0);
    chk({tag, " mc_addr"}, mc_addr, 0);
    chk({tag, " mc_write_data"}, mc_write_data, 0);
    chk({tag, " mc_write_mask"}, mc_write_mask, 0);
    chk({tag, " cl_busy"}, cl_busy, 0);
    chk({tag, " cl_done"}, cl_done, 0);
    chk({tag, " cl_err"}, cl_err, 0);
    chk({tag, " cl_read_data lo"}, cl_read_data[63:0], 0);
    chk({tag, " cl_read_data hi"}, cl_read_data[127:64], 0);
  endtask

  initial begin
    logic [31:0] wexp;
    logic [3:0] mexp;
    RST_N = 1'b0;
    cl_rw_flag = '0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    mc_read_data = '0;
    for (int i = 0; i < 4; i++) begin
      cl_addr[i*32 +: 32] = 32'(i * 32'h100);
      cl_write_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      cl_write_mask[i*4 +: 4] = 4'(i + 1);
    end
    // round robin from reset: 0,2,3 then 0,3
    add(8'hA2, 0, 0, 0,            0, 0,      4'b1101, 0, 0);
    add(8'h00, 0, 0, 0,            2, 32'h000, 4'b1101, 0, 0);
    add(8'h00, 0, 1, 32'h1111_1111, 0, 0,      4'b1100, 4'b0001, 0);
    add(8'h00, 0, 0, 0,            2, 32'h200, 4'b1100, 0, 0);
    add(8'h00, 0, 1, 0,            0, 0,      4'b1000, 4'b0100, 0);
    add(8'h00, 0, 0, 0,            2, 32'h300, 4'b1000, 0, 0);
    add(8'h00, 0, 1, 0,            0, 0,      4'b0000, 4'b1000, 0);
    add(8'h82, 0, 0, 0,            0, 0,      4'b1001, 0, 0);
    add(8'h00, 0, 0, 0,            2, 32'h000, 4'b1001, 0, 0);
    add(8'h00, 0, 1, 0,            0, 0,      4'b1000, 4'b0001, 0);
    add(8'h00, 0, 0, 0,            2, 32'h300, 4'b1000, 0, 0);
    add(8'h00, 0, 1, 0,            0, 0,      4'b0000, 4'b1000, 0);
    // single read, client 1
    add(8'h04, 0, 0, 0,            0, 0,      4'b0010, 0, 0);
    add(8'h00, 0, 0, 0,            1, 32'h100, 4'b0010, 0, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0010, 0, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0010, 0, 0);
    add(8'h00, 0, 1, 32'hDEAD_BEEF, 0, 0,      4'b0000, 4'b0010, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0000, 0, 0);
    // reserved flag never captured
    add(8'h0C, 0, 0, 0,            0, 0,      4'b0000, 0, 0);
    add(8'h0C, 0, 0, 0,            0, 0,      4'b0000, 0, 0);
    // back-pressure: mc_busy high 5 cycles with client 0 pending
    add(8'h01, 1, 0, 0,            0, 0,      4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h00, 1, 0, 0, 0, 0, 4'b0001, 0, 0);
    add(8'h00, 0, 0, 0,            1, 32'h000, 4'b0001, 0, 0);
    add(8'h00, 0, 1, 32'h1234_5678, 0, 0,      4'b0000, 4'b0001, 0);
    // timeout on client 3 then a stray mc_done
    add(8'h40, 0, 0, 0,            0, 0,      4'b1000, 0, 0);
    add(8'h00, 0, 0, 0,            1, 32'h300, 4'b1000, 0, 0);
    for (int i = 0; i < 7; i++) add(8'h00, 0, 0, 0, 0, 0, 4'b1000, 0, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0000, 4'b1000, 4'b1000);
    add(8'h00, 0, 1, 32'hBAD0_BAD0, 0, 0,      4'b0000, 0, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0000, 0, 0);
    // client 2 holds its read flag across completion
    add(8'h10, 0, 0, 0,            0, 0,      4'b0100, 0, 0);
    add(8'h10, 0, 0, 0,            1, 32'h200, 4'b0100, 0, 0);
    add(8'h10, 0, 1, 32'hCAFE_F00D, 0, 0,      4'b0000, 4'b0100, 0);
    add(8'h10, 0, 0, 0,            0, 0,      4'b0100, 0, 0);
    add(8'h00, 0, 0, 0,            1, 32'h200, 4'b0100, 0, 0);
    add(8'h00, 0, 1, 32'h0BAD_CAFE, 0, 0,      4'b0000, 4'b0100, 0);
    add(8'h00, 0, 0, 0,            0, 0,      4'b0000, 0, 0);

    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;

    for (int n = 0; n < tv.size(); n++) begin
      step(tv[n].f, tv[n].b, tv[n].d, tv[n].rd);
      chk($sformatf("v%0d mc_rw_flag", n), mc_rw_flag, tv[n].emf);
      chk($sformatf("v%0d cl_busy", n), cl_busy, tv[n].eb);
      chk($sformatf("v%0d cl_done", n), cl_done, tv[n].ed);
      chk($sformatf("v%0d cl_err", n), cl_err, tv[n].ee);
      if (tv[n].emf != 2'd0) begin
        wexp = {28'hA00_0000, tv[n].ea[11:8]};
        mexp = tv[n].ea[11:8] + 4'd1;
        chk($sformatf("v%0d mc_addr", n), mc_addr, tv[n].ea);
        chk($sformatf("v%0d mc_write_data", n), mc_write_data, wexp);
        chk($sformatf("v%0d mc_write_mask", n), mc_write_mask, mexp);
      end
    end
    chk("read_data c0", cl_read_data[31:0], 32'h1234_5678);
    chk("read_data c1", cl_read_data[63:32], 32'hDEAD_BEEF);
    chk("read_data c2", cl_read_data[95:64], 32'h0BAD_CAFE);
    chk("read_data c3", cl_read_data[127:96], 32'h0);

    // async reset in the middle of a read by client 1
    step(8'h04, 0, 0, 0);
    step(8'h00, 0, 0, 0);
    chk("pre-reset mc_rw_flag", mc_rw_flag, 2'd1);
    step(8'h00, 0, 0, 0);
    chk("pre-reset cl_busy", cl_busy, 4'b0010);
    #2 RST_N = 1'b0;
    #1 chk_all_zero("async reset");
    mc_done = 1'b1;
    @(negedge CLK);
    chk("held reset cl_done", cl_done, 0);
    RST_N = 1'b1;
    step(8'h00, 0, 1, 32'h5555_5555);
    chk("stray done after reset", cl_done, 0);
    chk("stray done busy", cl_busy, 0);
    step(8'h11, 0, 0, 0);
    chk("post-reset capture", cl_busy, 4'b0101);
    step(8'h00, 0, 0, 0);
    chk("post-reset first flag", mc_rw_flag, 2'd1);
    chk("post-reset first addr", mc_addr, 32'h000);
    step(8'h00, 0, 1, 32'h0000_00AA);
    chk("post-reset done c0", cl_done, 4'b0001);
    step(8'h00, 0, 0, 0);
    chk("post-reset second addr", mc_addr, 32'h200);
    chk("post-reset second flag", mc_rw_flag, 2'd1);
    step(8'h00, 0, 1, 32'h0000_00BB);
    chk("post-reset done c2", cl_done, 4'b0100);
    chk("post-reset read c0", cl_read_data[31:0], 32'h0000_00AA);
    chk("post-reset read c2", cl_read_data[95:64], 32'h0000_00BB);
    chk("post-reset read c1", cl_read_data[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
